reorder_buffer: RTL and testbench

//  Circular in-order reorder buffer feeding the commit stage. Dispatch allocates entries in

---
 rtl/reorder_buffer.sv | 111 +++++++++++
 tb/tb_reorder_buffer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: dispatch allocates at the tail, the CDB completes entries
// by tag, and the oldest completed entry retires to the commit stage at most once per cycle.
module reorder_buffer #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned TAG_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             alloc_valid,
  input  logic [4:0]       alloc_dest_reg,
  input  logic [3:0]       alloc_instr_type,
  output logic             alloc_ready,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [XLEN-1:0]  cdb_result,
  output logic             rob_valid,
  output logic [XLEN-1:0]  rob_result,
  output logic [4:0]       rob_dest_reg,
  output logic [3:0]       rob_instr_type,
  output logic [TAG_W:0]   rob_count
);

  localparam int unsigned CNT_W = TAG_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] done;
  logic [4:0]       dest_q   [DEPTH];
  logic [3:0]       type_q   [DEPTH];
  logic [XLEN-1:0]  result_q [DEPTH];
  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic alloc_fire;
  logic cdb_fire;
  logic retire_fire;

  // Handshake decisions, all taken from registered state.
  always_comb begin
    alloc_ready = (count != FULL);
    alloc_tag   = tail;
    rob_count   = count;
    alloc_fire  = alloc_valid & alloc_ready;
    cdb_fire    = cdb_valid & busy[cdb_tag];
    retire_fire = busy[head] & done[head];
  end

  // Entry status and pointers; retire is applied last so it wins over a repeat completion.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      busy  <= '0;
      done  <= '0;
    end else begin
      if (alloc_fire) begin
        busy[tail] <= 1'b1;
        done[tail] <= 1'b0;
        tail       <= tail + TAG_W'(1);
      end
      if (cdb_fire) begin
        done[cdb_tag] <= 1'b1;
      end
      if (retire_fire) begin
        busy[head] <= 1'b0;
        done[head] <= 1'b0;
        head       <= head + TAG_W'(1);
      end
      count <= count + CNT_W'(alloc_fire) - CNT_W'(retire_fire);
    end
  end

  // Payload storage needs no reset: busy/done qualify every read.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      if (alloc_fire) begin
        dest_q[tail]   <= alloc_dest_reg;
        type_q[tail]   <= alloc_instr_type;
        result_q[tail] <= '0;
      end
      if (cdb_fire) begin
        result_q[cdb_tag] <= cdb_result;
      end
    end
  end

  // Commit-stage outputs; data holds between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      rob_valid      <= 1'b0;
      rob_result     <= '0;
      rob_dest_reg   <= '0;
      rob_instr_type <= '0;
    end else if (flush) begin
      rob_valid <= 1'b0;
    end else begin
      rob_valid <= retire_fire;
      if (retire_fire) begin
        rob_result     <= result_q[head];
        rob_dest_reg   <= dest_q[head];
        rob_instr_type <= type_q[head];
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed table, corner sequences and a random run
// checked against a program-order queue model.
module tb_reorder_buffer;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             alloc_valid;
  logic [4:0]       alloc_dest_reg;
  logic [3:0]       alloc_instr_type;
  logic             alloc_ready;
  logic [TAG_W-1:0] alloc_tag;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [XLEN-1:0]  cdb_result;
  logic             rob_valid;
  logic [XLEN-1:0]  rob_result;
  logic [4:0]       rob_dest_reg;
  logic [3:0]       rob_instr_type;
  logic [TAG_W:0]   rob_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reorder_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_dest_reg(alloc_dest_reg),
    .alloc_instr_type(alloc_instr_type), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_result(cdb_result),
    .rob_valid(rob_valid), .rob_result(rob_result), .rob_dest_reg(rob_dest_reg),
    .rob_instr_type(rob_instr_type), .rob_count(rob_count)
  );

  // Reference model: in-flight instructions in program order.
  typedef struct {
    int          tag;
    logic [4:0]  dest;
    logic [3:0]  typ;
    bit          done;
    logic [31:0] result;
  } ent_t;

  ent_t        q[$];
  int          next_tag;
  logic        exp_valid;
  logic [31:0] exp_result;
  logic [4:0]  exp_dest;
  logic [3:0]  exp_type;

  typedef struct {
    bit          fl;
    bit          av;
    logic [4:0]  d;
    logic [3:0]  t;
    bit          cv;
    logic [3:0]  ct;
    logic [31:0] cr;
    bit          ev;
    logic [31:0] er;
    logic [4:0]  ed;
    logic [3:0]  et;
    logic [4:0]  ec;
    logic [3:0]  etag;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      q.delete();
      next_tag   = 0;
      exp_valid  = 1'b0;
      exp_result = '0;
      exp_dest   = '0;
      exp_type   = '0;
    end else if (flush) begin
      q.delete();
      next_tag  = 0;
      exp_valid = 1'b0;
    end else begin
      bit   ready = (q.size() < int'(DEPTH));
      bit   ret   = (q.size() > 0) && q[0].done;
      ent_t old;
      if (ret) old = q[0];
      if (cdb_valid) begin
        foreach (q[i]) begin
          if (q[i].tag == int'(cdb_tag)) begin
            q[i].done   = 1'b1;
            q[i].result = cdb_result;
          end
        end
      end
      if (ret) begin
        exp_valid  = 1'b1;
        exp_result = old.result;
        exp_dest   = old.dest;
        exp_type   = old.typ;
        void'(q.pop_front());
      end else begin
        exp_valid = 1'b0;
      end
      if (alloc_valid && ready) begin
        q.push_back('{next_tag, alloc_dest_reg, alloc_instr_type, 1'b0, 32'h0});
        next_tag = (next_tag + 1) % int'(DEPTH);
      end
    end
  endtask

  task automatic check_model();
    chk("model_alloc_ready", 32'(alloc_ready), 32'(q.size() < int'(DEPTH)));
    chk("model_alloc_tag",   32'(alloc_tag),   32'(next_tag));
    chk("model_rob_count",   32'(rob_count),   32'(q.size()));
    chk("model_rob_valid",   32'(rob_valid),   32'(exp_valid));
    chk("model_rob_result",  rob_result,       exp_result);
    chk("model_rob_dest",    32'(rob_dest_reg),   32'(exp_dest));
    chk("model_rob_type",    32'(rob_instr_type), 32'(exp_type));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic set_in(input bit fl, input bit av, input logic [4:0] d, input logic [3:0] t,
                        input bit cv, input logic [3:0] ct, input logic [31:0] cr);
    flush            = fl;
    alloc_valid      = av;
    alloc_dest_reg   = d;
    alloc_instr_type = t;
    cdb_valid        = cv;
    cdb_tag          = ct;
    cdb_result       = cr;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    step();
    rst = 1'b0;
  endtask

  initial begin
    int ord[4] = '{3, 1, 2, 0};

    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0);

    // Reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset_ready", 32'(alloc_ready), 32'd1);
      chk("reset_tag",   32'(alloc_tag),   32'd0);
      chk("reset_count", 32'(rob_count),   32'd0);
      chk("reset_valid", 32'(rob_valid),   32'd0);
    end
    rst = 1'b0;

    // Single instruction round trip, stray CDB, alloc+retire at count 3
    tbl[0]  = '{0, 1, 5'd5, 4'd1, 0, 4'd0, 32'h0,        0, 32'h0,        5'd0, 4'd0, 5'd1, 4'd1};
    tbl[1]  = '{0, 0, 5'd0, 4'd0, 1, 4'd0, 32'hDEADBEEF, 0, 32'h0,        5'd0, 4'd0, 5'd1, 4'd1};
    tbl[2]  = '{0, 0, 5'd0, 4'd0, 0, 4'd0, 32'h0,        1, 32'hDEADBEEF, 5'd5, 4'd1, 5'd0, 4'd1};
    tbl[3]  = '{0, 0, 5'd0, 4'd0, 0, 4'd0, 32'h0,        0, 32'hDEADBEEF, 5'd5, 4'd1, 5'd0, 4'd1};
    tbl[4]  = '{0, 0, 5'd0, 4'd0, 1, 4'd7, 32'h1234,     0, 32'hDEADBEEF, 5'd5, 4'd1, 5'd0, 4'd1};
    tbl[5]  = '{0, 1, 5'd1, 4'd2, 0, 4'd0, 32'h0,        0, 32'hDEADBEEF, 5'd5, 4'd1, 5'd1, 4'd2};
    tbl[6]  = '{0, 1, 5'd2, 4'd3, 0, 4'd0, 32'h0,        0, 32'hDEADBEEF, 5'd5, 4'd1, 5'd2, 4'd3};
    tbl[7]  = '{0, 1, 5'd3, 4'd4, 0, 4'd0, 32'h0,        0, 32'hDEADBEEF, 5'd5, 4'd1, 5'd3, 4'd4};
    tbl[8]  = '{0, 0, 5'd0, 4'd0, 1, 4'd1, 32'h11,       0, 32'hDEADBEEF, 5'd5, 4'd1, 5'd3, 4'd4};
    tbl[9]  = '{0, 1, 5'd4, 4'd5, 0, 4'd0, 32'h0,        1, 32'h11,       5'd1, 4'd2, 5'd3, 4'd5};
    tbl[10] = '{0, 0, 5'd0, 4'd0, 0, 4'd0, 32'h0,        0, 32'h11,       5'd1, 4'd2, 5'd3, 4'd5};

    foreach (tbl[i]) begin
      set_in(tbl[i].fl, tbl[i].av, tbl[i].d, tbl[i].t, tbl[i].cv, tbl[i].ct, tbl[i].cr);
      step();
      chk($sformatf("tbl%0d_valid", i),  32'(rob_valid),      32'(tbl[i].ev));
      chk($sformatf("tbl%0d_result", i), rob_result,          tbl[i].er);
      chk($sformatf("tbl%0d_dest", i),   32'(rob_dest_reg),   32'(tbl[i].ed));
      chk($sformatf("tbl%0d_type", i),   32'(rob_instr_type), 32'(tbl[i].et));
      chk($sformatf("tbl%0d_count", i),  32'(rob_count),      32'(tbl[i].ec));
      chk($sformatf("tbl%0d_tag", i),    32'(alloc_tag),      32'(tbl[i].etag));
      chk($sformatf("tbl%0d_ready", i),  32'(alloc_ready),    32'd1);
    end

    // Out-of-order completion, in-order retire
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_in(0, 1, 5'(10 + i), 4'(i), 0, 0, 0);
      step();
    end
    foreach (ord[k]) begin
      set_in(0, 0, 0, 0, 1, 4'(ord[k]), 32'h300 + 32'(ord[k]));
      step();
      chk("ooo_no_retire", 32'(rob_valid), 32'd0);
    end
    set_in(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("ooo_pulse",  32'(rob_valid),    32'd1);
      chk("ooo_result", rob_result,        32'h300 + 32'(i));
      chk("ooo_dest",   32'(rob_dest_reg), 32'(10 + i));
    end
    step();
    chk("ooo_drained_valid", 32'(rob_valid), 32'd0);
    chk("ooo_drained_count", 32'(rob_count), 32'd0);

    // Full buffer: held alloc ignored, retire does not admit same-cycle alloc, then wrap
    do_reset();
    for (int i = 0; i < 16; i++) begin
      set_in(0, 1, 5'(i), 4'(i), 0, 0, 0);
      step();
    end
    chk("full_count", 32'(rob_count),   32'd16);
    chk("full_ready", 32'(alloc_ready), 32'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("full_hold_count", 32'(rob_count), 32'd16);
    end
    set_in(0, 1, 0, 0, 1, 4'd0, 32'hAA);
    step();
    chk("full_cdb_valid", 32'(rob_valid), 32'd0);
    chk("full_cdb_count", 32'(rob_count), 32'd16);
    set_in(0, 1, 5'd9, 4'd9, 0, 0, 0);
    step();
    chk("full_retire_valid",  32'(rob_valid), 32'd1);
    chk("full_retire_result", rob_result,     32'hAA);
    chk("full_retire_count",  32'(rob_count), 32'd15);
    chk("full_retire_tag",    32'(alloc_tag), 32'd0);
    step();
    chk("full_wrap_count", 32'(rob_count), 32'd16);
    chk("full_wrap_tag",   32'(alloc_tag), 32'd1);
    chk("full_wrap_valid", 32'(rob_valid), 32'd0);

    // Flush with a coincident CDB, then a stale CDB to a flushed tag
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_in(0, 1, 5'(i), 4'd1, 0, 0, 0);
      step();
    end
    set_in(0, 0, 0, 0, 1, 4'd2, 32'h22);
    step();
    set_in(0, 0, 0, 0, 1, 4'd5, 32'h55);
    step();
    set_in(1, 0, 0, 0, 1, 4'd0, 32'h77);
    step();
    chk("flush_count", 32'(rob_count), 32'd0);
    chk("flush_valid", 32'(rob_valid), 32'd0);
    chk("flush_tag",   32'(alloc_tag), 32'd0);
    set_in(0, 1, 5'd3, 4'd2, 0, 0, 0);
    step();
    chk("flush_alloc_count", 32'(rob_count), 32'd1);
    set_in(0, 0, 0, 0, 1, 4'd5, 32'h99);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("flush_stale_valid", 32'(rob_valid), 32'd0);
      chk("flush_stale_count", 32'(rob_count), 32'd1);
    end

    // Random traffic against the queue model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] t;
      if (q.size() > 0 && $urandom_range(3) != 0)
        t = 4'(q[$urandom_range(q.size() - 1)].tag);
      else
        t = 4'($urandom_range(15));
      rst = ($urandom_range(255) == 0);
      set_in($urandom_range(63) == 0, $urandom_range(9) < 6, 5'($urandom), 4'($urandom),
             $urandom_range(1) == 1, t, $urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
